// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - program counter with next-PC select, stall-deferred redirect, jr trap and retired counter
module pc_next_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchOffset,
  input  logic        jump,
  input  logic [27:0] jumpTarget,
  input  logic        jumpReg,
  input  logic [31:0] regTarget,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        redirectPending,
  output logic        addrError,
  output logic [31:0] retiredCount
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pendTarget;
  logic        pendErr;

  logic [31:0] sel_target;
  logic        sel_err;
  logic        redirect;

  assign pcPlus4         = pc + 32'd4;
  assign redirectPending = (state == PEND);

  // Pick the next fetch address by priority jr > j > branch > sequential.
  always_comb begin
    sel_target = pcPlus4;
    sel_err    = 1'b0;
    redirect   = 1'b0;
    if (jumpReg) begin
      redirect = 1'b1;
      if (regTarget[1:0] != 2'b00) begin
        sel_target = EXC_VECTOR;
        sel_err    = 1'b1;
      end else begin
        sel_target = regTarget;
      end
    end else if (jump) begin
      redirect   = 1'b1;
      sel_target = {pcPlus4[31:28], jumpTarget};
    end else if (branchTaken) begin
      redirect   = 1'b1;
      sel_target = pcPlus4 + (branchOffset << 2);
    end
  end

  // PC update and redirect deferral; a captured redirect is replayed on the first unstalled edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      pc           <= RESET_PC;
      pendTarget   <= 32'h0000_0000;
      pendErr      <= 1'b0;
      addrError    <= 1'b0;
      retiredCount <= 32'h0000_0000;
    end else begin
      case (state)
        RUN: begin
          if (!stall) begin
            pc           <= sel_target;
            retiredCount <= retiredCount + 32'd1;
            if (sel_err) addrError <= 1'b1;
          end else if (redirect) begin
            pendTarget <= sel_target;
            pendErr    <= sel_err;
            state      <= PEND;
          end
        end
        PEND: begin
          if (!stall) begin
            pc           <= pendTarget;
            retiredCount <= retiredCount + 32'd1;
            if (pendErr) addrError <= 1'b1;
            state        <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
